obi_sram_bridge: RTL and testbench
==================================

Name: obi_sram_bridge

Overview:
- Slave-side adapter downstream of the core's instruction or data OBI-style port (req/gnt/rvalid). Converts it to a single-port synchronous SRAM interface with fixed read latency.
- Out-of-range accesses are flagged as bus errors without touching the SRAM.
- The SRAM port is shared, so an external arbiter may withhold grant through mem_gnt_i.
- One instance per port: instruction side and data side.

Parameters:
AddrWidth, 14, SRAM word-address width; size is 4*2^AddrWidth bytes.
BaseAddr, 32'h0000_0000, byte base address of the SRAM window; must be word aligned.
MemLatency, 1, SRAM read latency in cycles; legal values are 1 and 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
req_i  in  1  request from core
gnt_o  out  1  request accepted this cycle
addr_i  in  32  byte address; bits [1:0] ignored
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data
err_o  out  1  response is a bus error
mem_req_o  out  1  SRAM access request
mem_gnt_i  in  1  arbiter grants the SRAM port this cycle
mem_we_o  out  1  SRAM write enable
mem_be_o  out  4  SRAM byte enables
mem_addr_o  out  AddrWidth  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid MemLatency cycles after a granted read
err_cnt_o  out  8  saturating count of error responses
err_clr_i  in  1  synchronous clear of err_cnt_o

Behaviour:
- Address decode (combinational):
  - in_range = (addr_i >= BaseAddr) && (addr_i < BaseAddr + 4*2^AddrWidth), evaluated in 33-bit arithmetic so the upper bound cannot wrap.
  - mem_addr_o = (addr_i - BaseAddr)[AddrWidth+1:2].
- Request path (combinational, no request buffering):
  - mem_req_o = req_i & in_range.
  - mem_we_o, mem_be_o and mem_wdata_o pass straight through from we_i, be_i and wdata_i.
  - gnt_o = req_i & (!in_range | mem_gnt_i).
  - A request is accepted in cycle T when req_i & gnt_o.
  - If in range and mem_gnt_i = 0: gnt_o stays 0 and the core holds the request; there is no timeout.
- Response pipeline:
  - MemLatency-deep shift register of {valid, is_read, is_err}, loaded on acceptance.
  - rvalid_o is high exactly in cycle T+MemLatency for each request accepted at T.
  - Responses return in order. Back-to-back acceptance every cycle sustains one response per cycle with no bubbles.
  - rdata_o = mem_rdata_i when the response is an in-range read; otherwise 32'h0. rdata_o is also 0 whenever rvalid_o = 0.
  - err_o = 1 only with rvalid_o on out-of-range responses. An out-of-range access never asserts mem_req_o but still returns its response at the same fixed latency, so ordering is preserved.
  - Writes and reads with be_i = 0 are legal: the SRAM is accessed and a normal response is returned.
- Error counter:
  - err_cnt_o increments on each cycle with rvalid_o & err_o.
  - Saturates at 8'hFF.
  - err_clr_i has priority: a clear and an increment in the same cycle give 0.
- Reset (asynchronous, rst_ni low):
  - All pipeline valid bits and err_cnt_o cleared.
  - rvalid_o = 0, err_o = 0, rdata_o = 0.
  - Responses in flight at reset are dropped and never presented.
  - gnt_o and mem_req_o follow req_i combinationally and are only meaningful once out of reset; the core does not request during reset.
- No state machine beyond the latency pipeline. No internal backpressure: the core accepts rvalid unconditionally.

Test Plan:
1. MemLatency=1, BaseAddr=0: write 32'hDEADBEEF with be=4'hF to addr 0x10, then read 0x10 and 0x14 on consecutive cycles -> gnt_o same cycle as req; mem_addr_o = 4 then 5; rvalid_o at T+1 and T+2; rdata_o = 32'hDEADBEEF on the first read; err_o = 0.
2. Boundary, AddrWidth=14, BaseAddr=32'h1000_0000: read 0x1000_FFFC then 0x1001_0000 -> first gives mem_req_o=1 and mem_addr_o=14'h3FFF; second gives no mem_req_o, gnt_o=1, rvalid_o with err_o=1 and rdata_o=0 one cycle later, in order. A read of 0x0FFF_FFFC also errors.
3. Arbitration: hold req_i with mem_gnt_i=0 for 3 cycles, then raise it -> gnt_o=0 for those 3 cycles; a single acceptance on the 4th cycle; exactly one rvalid_o one cycle later.
4. MemLatency=2: 4 back-to-back reads -> rvalid_o high for 4 consecutive cycles starting T+2; rdata matches in order.
5. Error counter: 300 out-of-range accesses -> err_cnt_o = 8'hFF. Then err_clr_i coincident with an error response -> err_cnt_o = 0 next cycle.
6. Reset mid-flight with MemLatency=2: assert rst_ni low one cycle after acceptance -> rvalid_o never asserts for that request; err_cnt_o = 0; the next post-reset read returns normally.

Source files
------------

// File: rtl/obi_sram_bridge.sv
// rtl/obi_sram_bridge.sv - OBI req/gnt/rvalid slave to single-port fixed-latency SRAM bridge
`timescale 1ns/1ps
module obi_sram_bridge #(
  parameter int unsigned AddrWidth  = 14,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned MemLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [7:0]           err_cnt_o,
  input  logic                 err_clr_i
);

  logic [32:0] w_addr_ext;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  logic        w_in_range;
  logic        w_accept;
  logic        w_resp_vld;
  logic        w_resp_rd;
  logic        w_resp_err;

  logic [MemLatency-1:0] r_vld;
  logic [MemLatency-1:0] r_rd;
  logic [MemLatency-1:0] r_err;
  logic [7:0]            r_err_cnt;

  // 33-bit compare so a window ending at 4 GiB does not wrap to zero
  assign w_addr_ext = {1'b0, addr_i};
  assign w_lo       = {1'b0, BaseAddr};
  assign w_hi       = w_lo + (33'd1 << (AddrWidth + 2));
  assign w_in_range = (w_addr_ext >= w_lo) && (w_addr_ext < w_hi);

  assign mem_addr_o  = AddrWidth'((addr_i - BaseAddr) >> 2);
  assign mem_req_o   = req_i & w_in_range;
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  // Out-of-range requests are granted at once; they never wait for the arbiter
  assign gnt_o    = req_i & (~w_in_range | mem_gnt_i);
  assign w_accept = req_i & gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld     <= '0;
      r_rd      <= '0;
      r_err     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_rd[0]  <= ~we_i;
      r_err[0] <= ~w_in_range;
      for (int i = 1; i < MemLatency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
        r_err[i] <= r_err[i-1];
      end
      if (err_clr_i) begin
        r_err_cnt <= '0;
      end else if (w_resp_vld && w_resp_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign w_resp_vld = r_vld[MemLatency-1];
  assign w_resp_rd  = r_rd[MemLatency-1];
  assign w_resp_err = r_err[MemLatency-1];

  assign rvalid_o  = w_resp_vld;
  assign err_o     = w_resp_vld & w_resp_err;
  assign rdata_o   = (w_resp_vld && w_resp_rd && !w_resp_err) ? mem_rdata_i : 32'h0;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_obi_sram_bridge.sv
// tb/tb_obi_sram_bridge.sv - scoreboard bench for obi_sram_bridge over three parameter sets
`timescale 1ns/1ps
module tb_obi_sram_bridge;

  localparam int NI = 3;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    int          cyc;
    int          k;
    logic        gnt;
    logic        mreq;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [13:0] maddr;
  } reqchk_t;

  typedef struct {
    int         cyc;
    int         k;
    logic [7:0] cnt;
  } cntchk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  be;
  logic        err_clr;

  logic        req       [NI];
  logic        mem_gnt   [NI];
  logic        gnt       [NI];
  logic        rvalid    [NI];
  logic        err       [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [31:0] rdata     [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic [3:0]  mem_be    [NI];
  logic [13:0] mem_addr  [NI];
  logic [7:0]  err_cnt   [NI];

  rsp_t    q0[$];
  rsp_t    q1[$];
  rsp_t    q2[$];
  reqchk_t rq[$];
  cntchk_t cq[$];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // k=0: latency 1, base 0; k=1: latency 2, base 0; k=2: latency 1, base 0x1000_0000
  obi_sram_bridge #(.AddrWidth(14), .BaseAddr(32'h0000_0000), .MemLatency(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .mem_req_o(mem_req[0]), .mem_gnt_i(mem_gnt[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
    .err_cnt_o(err_cnt[0]), .err_clr_i(err_clr));

  obi_sram_bridge #(.AddrWidth(14), .BaseAddr(32'h0000_0000), .MemLatency(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .mem_req_o(mem_req[1]), .mem_gnt_i(mem_gnt[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
    .err_cnt_o(err_cnt[1]), .err_clr_i(err_clr));

  obi_sram_bridge #(.AddrWidth(14), .BaseAddr(32'h1000_0000), .MemLatency(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
    .mem_req_o(mem_req[2]), .mem_gnt_i(mem_gnt[2]), .mem_we_o(mem_we[2]), .mem_be_o(mem_be[2]),
    .mem_addr_o(mem_addr[2]), .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata[2]),
    .err_cnt_o(err_cnt[2]), .err_clr_i(err_clr));

  // SRAM model: unwritten words read back as C0DE_0000 | k<<12 | low 8 address bits
  logic [31:0]  mem     [NI][256];
  logic [255:0] wr_mask [NI] = '{default: '0};
  logic [31:0]  s1      [NI];
  logic [31:0]  s2      [NI];
  logic [31:0]  wtmp;

  function automatic logic [31:0] rd_word(input int k, input logic [7:0] a);
    return wr_mask[k][a] ? mem[k][a] : (32'hC0DE_0000 | (32'(k) << 12) | 32'(a));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      s2[k] <= s1[k];
      if (mem_req[k] && mem_gnt[k]) begin
        if (mem_we[k]) begin
          wtmp = rd_word(k, mem_addr[k][7:0]);
          for (int b = 0; b < 4; b++)
            if (mem_be[k][b]) wtmp[8*b +: 8] = mem_wdata[k][8*b +: 8];
          mem[k][mem_addr[k][7:0]]     <= wtmp;
          wr_mask[k][mem_addr[k][7:0]] <= 1'b1;
        end else begin
          s1[k] <= rd_word(k, mem_addr[k][7:0]);
        end
      end
    end
  end

  assign mem_rdata[0] = s1[0];
  assign mem_rdata[1] = s2[1];
  assign mem_rdata[2] = s1[2];

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic void chk(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
    end
  endfunction

  // Monitor: all comparisons happen here, on the falling edge
  reqchk_t r;
  cntchk_t c;
  rsp_t    e;
  bit      got;
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      chk("gnt", r.k, 32'(gnt[r.k]), 32'(r.gnt));
      chk("mem_req", r.k, 32'(mem_req[r.k]), 32'(r.mreq));
      if (r.mreq) begin
        chk("mem_addr", r.k, 32'(mem_addr[r.k]), 32'(r.maddr));
        chk("mem_we", r.k, 32'(mem_we[r.k]), 32'(r.we));
        chk("mem_be", r.k, 32'(mem_be[r.k]), 32'(r.be));
        chk("mem_wdata", r.k, mem_wdata[r.k], r.wdata);
      end
    end
    while (cq.size() > 0 && cq[0].cyc == cyc) begin
      c = cq.pop_front();
      chk("err_cnt", c.k, 32'(err_cnt[c.k]), 32'(c.cnt));
    end
    for (int k = 0; k < NI; k++) begin
      if (rvalid[k] === 1'b1) begin
        got = 1'b0;
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
          default: ;
        endcase
        chk("rvalid_expected", k, 32'(got), 32'd1);
        if (got) begin
          chk("rsp_cycle", k, 32'(cyc), 32'(e.cyc));
          chk("err", k, 32'(err[k]), 32'(e.err));
          chk("rdata", k, rdata[k], e.rdata);
        end
      end else begin
        chk("idle_rvalid", k, 32'(rvalid[k]), 32'd0);
        chk("idle_err", k, 32'(err[k]), 32'd0);
        chk("idle_rdata", k, rdata[k], 32'd0);
      end
    end
    if (done) begin
      chk("pending_rsp0", 0, 32'(q0.size()), 32'd0);
      chk("pending_rsp1", 1, 32'(q1.size()), 32'd0);
      chk("pending_rsp2", 2, 32'(q2.size()), 32'd0);
      chk("pending_req_chk", 0, 32'(rq.size()), 32'd0);
      chk("pending_cnt_chk", 0, 32'(cq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] wd, input logic exp_gnt, input logic exp_mreq,
                       input logic [13:0] exp_maddr, input bit exp_rsp, input logic exp_err,
                       input logic [31:0] exp_rd);
    reqchk_t rc;
    rsp_t    rs;
    for (int j = 0; j < NI; j++) req[j] = 1'b0;
    req[k] = 1'b1;
    addr   = a;
    we     = w;
    be     = b;
    wdata  = wd;
    rc.cyc = cyc; rc.k = k; rc.gnt = exp_gnt; rc.mreq = exp_mreq;
    rc.we = w; rc.be = b; rc.wdata = wd; rc.maddr = exp_maddr;
    rq.push_back(rc);
    if (exp_gnt && exp_rsp) begin
      rs.cyc = cyc + lat_of(k); rs.err = exp_err; rs.rdata = exp_rd;
      case (k)
        0: q0.push_back(rs);
        1: q1.push_back(rs);
        default: q2.push_back(rs);
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < NI; j++) req[j] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_cnt(input int k, input logic [7:0] v);
    cntchk_t cc;
    cc.cyc = cyc; cc.k = k; cc.cnt = v;
    cq.push_back(cc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; be = '0; err_clr = 1'b0;
    for (int j = 0; j < NI; j++) begin req[j] = 1'b0; mem_gnt[j] = 1'b1; end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) expect_cnt(k, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Write then two back-to-back reads, latency 1
    issue(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1, 1, 14'd4, 1, 0, 32'h0);
    issue(0, 32'h10, 1'b0, 4'hF, 32'h0, 1, 1, 14'd4, 1, 0, 32'hDEADBEEF);
    issue(0, 32'h14, 1'b0, 4'hF, 32'h0, 1, 1, 14'd5, 1, 0, 32'hC0DE_0005);
    idle(3);

    // Window edges with a non-zero base; out-of-range needs no arbiter grant
    issue(2, 32'h1000_FFFC, 1'b0, 4'hF, 32'h0, 1, 1, 14'h3FFF, 1, 0, 32'hC0DE_20FF);
    issue(2, 32'h1001_0000, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    mem_gnt[2] = 1'b0;
    issue(2, 32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    mem_gnt[2] = 1'b1;
    idle(2);
    expect_cnt(2, 8'd2);

    // Arbiter withholds the SRAM for three cycles
    mem_gnt[0] = 1'b0;
    repeat (3) issue(0, 32'h20, 1'b0, 4'hF, 32'h0, 0, 1, 14'd8, 0, 0, 32'h0);
    mem_gnt[0] = 1'b1;
    issue(0, 32'h20, 1'b0, 4'hF, 32'h0, 1, 1, 14'd8, 1, 0, 32'hC0DE_0008);
    idle(3);

    // Error counter: count, saturate, clear wins over increment
    for (int i = 0; i < 10; i++)
      issue(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    idle(1);
    expect_cnt(0, 8'd10);
    for (int i = 0; i < 290; i++)
      issue(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    idle(2);
    expect_cnt(0, 8'hFF);
    issue(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    for (int j = 0; j < NI; j++) req[j] = 1'b0;
    err_clr = 1'b1;
    expect_cnt(0, 8'hFF);
    @(posedge clk); #1;
    err_clr = 1'b0;
    expect_cnt(0, 8'h00);
    idle(2);

    // Latency 2: be=0 write leaves data intact, then four back-to-back reads
    issue(1, 32'h0, 1'b1, 4'h0, 32'hFFFF_FFFF, 1, 1, 14'd0, 1, 0, 32'h0);
    issue(1, 32'h0, 1'b0, 4'hF, 32'h0, 1, 1, 14'd0, 1, 0, 32'hC0DE_1000);
    issue(1, 32'h4, 1'b0, 4'hF, 32'h0, 1, 1, 14'd1, 1, 0, 32'hC0DE_1001);
    issue(1, 32'h8, 1'b0, 4'hF, 32'h0, 1, 1, 14'd2, 1, 0, 32'hC0DE_1002);
    issue(1, 32'hC, 1'b0, 4'hF, 32'h0, 1, 1, 14'd3, 1, 0, 32'hC0DE_1003);
    issue(1, 32'h0001_0000, 1'b0, 4'hF, 32'h0, 1, 0, 14'h0, 1, 1, 32'h0);
    idle(4);
    expect_cnt(1, 8'd1);

    // Reset one cycle after acceptance drops the in-flight response
    issue(1, 32'h4, 1'b0, 4'hF, 32'h0, 1, 1, 14'd1, 0, 0, 32'h0);
    for (int j = 0; j < NI; j++) req[j] = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) expect_cnt(k, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    issue(1, 32'h4, 1'b0, 4'hF, 32'h0, 1, 1, 14'd1, 1, 0, 32'hC0DE_1001);
    idle(4);
    done = 1'b1;
  end

endmodule
